// File: rtl/flex_updown_counter.sv
// flex_updown_counter
//   Up/down counter over the range 0..rollover_val with wrap, saturate and
//   one-shot terminal behaviour, synchronous clear/load and registered
//   status outputs.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active-high
//   clear          synchronous clear (count and done to 0)
//   count_enable   advance one step this cycle
//   dir            1 = count up, 0 = count down
//   mode           00 wrap, 01 saturate, 10 one-shot, 11 behaves as wrap
//   load           synchronous load of load_val
//   load_val       value loaded when load = 1
//   rollover_val   upper bound R of the count range
//   count_out      current count
//   rollover_flag  count_out equals the terminal value (R going up, 0 going down)
//   rollover_pulse a wrap step was taken on the previous edge
//   done           one-shot mode reached its terminal value and halted
module flex_updown_counter #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic                dir,
    input  logic [1:0]          mode,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_val,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag,
    output logic                rollover_pulse,
    output logic                done
);

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

    logic [NUM_BITS-1:0] count_q, count_d;
    logic                flag_q, flag_d;
    logic                pulse_q, pulse_d;
    logic                done_q, done_d;

    logic                is_sat;
    logic                is_oneshot;
    logic                at_limit;
    logic [NUM_BITS-1:0] term_val;

    always_comb begin
        count_d    = count_q;
        pulse_d    = 1'b0;
        done_d     = done_q;
        is_sat     = (mode == MODE_SAT);
        is_oneshot = (mode == MODE_ONESHOT);
        // Going up, anything at or above R counts as terminal so an
        // out-of-range load cannot run away past R.
        at_limit   = dir ? (count_q >= rollover_val) : (count_q == '0);

        if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (count_enable && !done_q) begin
            if (!at_limit) begin
                count_d = dir ? (count_q + ONE) : (count_q - ONE);
            end else if (is_oneshot) begin
                done_d = 1'b1;
            end else if (is_sat) begin
                // Holds at R; also clamps a count that was loaded above R.
                if (dir) begin
                    count_d = rollover_val;
                end
            end else begin
                count_d = dir ? '0 : rollover_val;
                pulse_d = 1'b1;
            end
        end

        if (!is_oneshot) begin
            done_d = 1'b0;
        end

        // Flag uses the next count and the dir sampled on this edge, so it
        // moves together with count_out.
        term_val = dir ? rollover_val : '0;
        flag_d   = (count_d == term_val);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    assign count_out      = count_q;
    assign rollover_flag  = flag_q;
    assign rollover_pulse = pulse_q;
    assign done           = done_q;

endmodule

// File: tb/tb_flex_updown_counter.sv
module tb_flex_updown_counter;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          count_enable;
    logic          dir;
    logic [1:0]    mode;
    logic          load;
    logic [NB-1:0] load_val;
    logic [NB-1:0] rollover_val;
    logic [NB-1:0] count_out;
    logic          rollover_flag;
    logic          rollover_pulse;
    logic          done;

    flex_updown_counter #(.NUM_BITS(NB)) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .count_enable  (count_enable),
        .dir           (dir),
        .mode          (mode),
        .load          (load),
        .load_val      (load_val),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .rollover_pulse(rollover_pulse),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_cnt   = 0;
    int m_flag  = 0;
    int m_pulse = 0;
    int m_done  = 0;

    int exp3[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_flag = 0; m_pulse = 0; m_done = 0;
    endtask

    // Behavioural rules applied to the inputs present before the edge.
    task automatic model_edge();
        int r;
        int c;
        int p;
        int d;
        int max_v;
        r     = int'(rollover_val);
        c     = m_cnt;
        p     = 0;
        d     = m_done;
        max_v = (1 << NB) - 1;
        if (clear) begin
            c = 0; d = 0;
        end else if (load) begin
            c = int'(load_val); d = 0;
        end else if (count_enable && m_done == 0) begin
            if (dir) begin
                if (c < r) c = c + 1;
                else if (mode == 2'd1) c = r;
                else if (mode == 2'd2) d = 1;
                else begin c = 0; p = 1; end
            end else begin
                if (c > 0) c = c - 1;
                else if (mode == 2'd1) c = 0;
                else if (mode == 2'd2) d = 1;
                else begin c = r; p = 1; end
            end
        end
        if (mode != 2'd2) d = 0;
        if (c > max_v || c < 0) c = c & max_v;
        m_cnt   = c;
        m_pulse = p;
        m_done  = d;
        m_flag  = (c == (dir ? r : 0)) ? 1 : 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"}, 32'(count_out),      32'(m_cnt));
        check({tag, ".flag"},  32'(rollover_flag),  32'(m_flag));
        check({tag, ".pulse"}, 32'(rollover_pulse), 32'(m_pulse));
        check({tag, ".done"},  32'(done),           32'(m_done));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic idle_inputs();
        clear = 0; load = 0; count_enable = 0;
    endtask

    initial begin
        rst = 1; clear = 0; count_enable = 0; dir = 1; mode = 2'd0;
        load = 0; load_val = '0; rollover_val = 4'd6;
        exp3[0] = 2; exp3[1] = 1; exp3[2] = 0; exp3[3] = 6;
        exp3[4] = 5; exp3[5] = 4; exp3[6] = 3; exp3[7] = 2;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst = 0;

        // async reset mid-count at count 5
        count_enable = 1;
        for (int i = 0; i < 5; i++) tick("pre_rst");
        check("pre_rst.at5", 32'(count_out), 32'd5);
        count_enable = 0;
        #2;
        rst = 1;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk);
        #1;
        check_model("rst_held");
        rst = 0;
        tick("rst_release");

        // wrap up, R=6
        count_enable = 1;
        for (int i = 0; i < 16; i++) begin
            tick("wrap_up");
            check("wrap_up.seq", 32'(count_out), 32'((i + 1) % 7));
            check("wrap_up.pulse_c", 32'(rollover_pulse), 32'(((i + 1) % 7) == 0));
        end

        // wrap down from loaded 3
        idle_inputs();
        dir = 0; load = 1; load_val = 4'd3;
        tick("load3");
        load = 0; count_enable = 1;
        for (int i = 0; i < 8; i++) begin
            tick("wrap_dn");
            check("wrap_dn.seq", 32'(count_out), 32'(exp3[i]));
        end

        // saturate, R=9
        idle_inputs();
        clear = 1; dir = 1; mode = 2'd1; rollover_val = 4'd9;
        tick("sat_clr");
        clear = 0; count_enable = 1;
        for (int i = 0; i < 15; i++) tick("sat");
        check("sat.final", 32'(count_out), 32'd9);
        count_enable = 0; load = 1; load_val = 4'd12;
        tick("sat_load12");
        check("sat.load12", 32'(count_out), 32'd12);
        load = 0; count_enable = 1;
        tick("sat_clamp");
        check("sat.clamp", 32'(count_out), 32'd9);

        // one-shot, R=4
        idle_inputs();
        clear = 1; mode = 2'd2; rollover_val = 4'd4;
        tick("os_clr");
        clear = 0; count_enable = 1;
        for (int i = 0; i < 7; i++) tick("os");
        check("os.count", 32'(count_out), 32'd4);
        check("os.done", 32'(done), 32'd1);
        count_enable = 0; clear = 1;
        tick("os_clear");
        check("os.clr_done", 32'(done), 32'd0);
        clear = 1; load = 1; load_val = 4'd3;
        tick("os_clr_load");
        check("os.clr_wins", 32'(count_out), 32'd0);

        // direction change mid-count, then R shrinks under the count
        idle_inputs();
        mode = 2'd0; rollover_val = 4'd7; dir = 1; clear = 1;
        tick("dirchg_clr");
        clear = 0; count_enable = 1;
        tick("dirchg_1");
        tick("dirchg_2");
        dir = 0;
        tick("dirchg_dn");
        check("dirchg.count", 32'(count_out), 32'd1);
        check("dirchg.flag", 32'(rollover_flag), 32'd0);
        count_enable = 0; dir = 1; load = 1; load_val = 4'd5;
        tick("rshrink_load");
        load = 0; count_enable = 1; rollover_val = 4'd1;
        tick("rshrink");
        check("rshrink.count", 32'(count_out), 32'd0);
        check("rshrink.pulse", 32'(rollover_pulse), 32'd1);

        // R == 0 in wrap mode
        rollover_val = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick("r0");
            check("r0.pulse", 32'(rollover_pulse), 32'd1);
        end

        // randomized
        for (int i = 0; i < 1500; i++) begin
            clear        = ($urandom_range(0, 24) == 0);
            load         = ($urandom_range(0, 11) == 0);
            count_enable = ($urandom_range(0, 3) != 0);
            load_val     = NB'($urandom);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 19) == 0) rollover_val = NB'($urandom);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
